loopback_link_ctrl: RTL and testbench

Bring-up and word-alignment controller for the HPIO TX→RX loopback path.
- Waits until both native-I/O PHYs report ready, then releases the counter data source from reset and drains the RX FIFO.
- Finds the bit-slip that turns the received serial byte stream back into an incrementing counter, then monitors the locked link for errors.
- Sits in the clk_160m domain between the HPIO_TX/HPIO_RX wrappers and counter_datagen.

---
 rtl/loopback_link_ctrl.sv | 165 ++++++++++++++++
 tb/tb_loopback_link_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/loopback_link_ctrl.sv
// Bring-up and word-alignment controller for the HPIO TX->RX loopback path.
// Waits for the PHYs, releases the counter source, finds the bit-slip and then monitors the locked link.
module loopback_link_ctrl #(
   parameter int LOCK_MATCHES = 16,
   parameter int LOSS_ERRS    = 4,
   parameter int PHY_TIMEOUT  = 4096,
   parameter int MAX_SLIPS    = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tx_rst_seq_done,
   input  logic        rx_rst_seq_done,
   input  logic        tx_pll_locked,
   input  logic        rx_pll_locked,
   input  logic        phy_dly_rdy,
   input  logic        phy_vtc_rdy,
   input  logic        rx_fifo_empty,
   output logic        rx_fifo_rd_en,
   input  logic        rx_data_valid,
   input  logic [7:0]  rx_data,
   output logic        source_rst,
   output logic [7:0]  aligned_data,
   output logic        aligned_valid,
   output logic [2:0]  slip,
   output logic [2:0]  state,
   output logic        link_locked,
   output logic        link_error,
   output logic [15:0] err_count
);
   localparam int TW = $clog2(PHY_TIMEOUT + 1);
   localparam int MW = $clog2(LOCK_MATCHES + 1);
   localparam int SW = $clog2(MAX_SLIPS + 1);
   localparam int LW = $clog2(LOSS_ERRS + 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WAIT_PHY = 3'd1,
      RELEASE  = 3'd2,
      ALIGN    = 3'd3,
      LOCKED   = 3'd4,
      FAIL     = 3'd6
   } state_t;

   state_t        cur_state, next_state;
   logic [TW-1:0] tmo_cnt;
   logic [MW-1:0] match_cnt;
   logic [SW-1:0] slip_cnt;
   logic [LW-1:0] miss_cnt;
   logic [7:0]    prev, last, cand;
   logic [15:0]   shifted;
   logic          seed, phy_ok, word_ok, take_word, enter_align, enter_locked;

   assign phy_ok = tx_rst_seq_done & rx_rst_seq_done & tx_pll_locked &
                   rx_pll_locked & phy_dly_rdy & phy_vtc_rdy;

   // The candidate word spans the current and previous raw bytes, selected by the slip.
   assign shifted      = {rx_data, prev} >> slip;
   assign cand         = shifted[7:0];
   assign word_ok      = (cand == 8'(last + 8'd1));
   assign take_word    = rx_data_valid & phy_ok;
   assign enter_align  = (next_state == ALIGN) && (cur_state != ALIGN);
   assign enter_locked = (next_state == LOCKED) && (cur_state != LOCKED);

   always_ff @(posedge clk) begin
      if (rst) cur_state <= IDLE;
      else     cur_state <= next_state;
   end

   // Loss of any PHY ready indication overrides every other transition.
   always_comb begin
      next_state    = cur_state;
      source_rst    = 1'b1;
      rx_fifo_rd_en = 1'b0;
      link_locked   = 1'b0;
      link_error    = 1'b0;
      state         = cur_state;
      case (cur_state)
         IDLE: next_state = WAIT_PHY;
         WAIT_PHY: begin
            if (phy_ok)                                  next_state = RELEASE;
            else if (tmo_cnt == TW'(PHY_TIMEOUT - 1))    next_state = FAIL;
         end
         RELEASE: begin
            source_rst    = 1'b0;
            rx_fifo_rd_en = ~rx_fifo_empty;
            if (!phy_ok)             next_state = WAIT_PHY;
            else if (!rx_fifo_empty) next_state = ALIGN;
         end
         ALIGN: begin
            source_rst    = 1'b0;
            rx_fifo_rd_en = ~rx_fifo_empty;
            if (!phy_ok) next_state = WAIT_PHY;
            else if (rx_data_valid && !seed) begin
               if (word_ok && match_cnt == MW'(LOCK_MATCHES - 1))    next_state = LOCKED;
               else if (!word_ok && slip_cnt == SW'(MAX_SLIPS - 1)) next_state = FAIL;
            end
         end
         LOCKED: begin
            source_rst    = 1'b0;
            rx_fifo_rd_en = ~rx_fifo_empty;
            link_locked   = 1'b1;
            if (!phy_ok) next_state = WAIT_PHY;
            else if (rx_data_valid && !word_ok && miss_cnt == LW'(LOSS_ERRS - 1))
               next_state = ALIGN;
         end
         FAIL:    link_error = 1'b1;
         default: next_state = IDLE;
      endcase
   end

   // Alignment search, lock monitoring and error accounting.
   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_cnt       <= '0;
         match_cnt     <= '0;
         slip_cnt      <= '0;
         miss_cnt      <= '0;
         prev          <= '0;
         last          <= '0;
         seed          <= 1'b0;
         slip          <= '0;
         err_count     <= '0;
         aligned_data  <= '0;
         aligned_valid <= 1'b0;
      end else begin
         aligned_valid <= 1'b0;
         if (rx_data_valid) prev <= rx_data;
         tmo_cnt <= (cur_state == WAIT_PHY && next_state == WAIT_PHY) ? tmo_cnt + 1'b1 : '0;

         if (cur_state == ALIGN && take_word) begin
            last <= cand;
            if (seed) begin
               seed <= 1'b0;
            end else if (word_ok) begin
               match_cnt <= match_cnt + 1'b1;
            end else begin
               match_cnt <= '0;
               slip      <= slip + 3'd1;
               slip_cnt  <= slip_cnt + 1'b1;
               seed      <= 1'b1;
            end
         end

         if (cur_state == LOCKED && take_word) begin
            aligned_valid <= 1'b1;
            aligned_data  <= cand;
            last          <= cand;
            if (word_ok) begin
               miss_cnt <= '0;
            end else begin
               miss_cnt <= miss_cnt + 1'b1;
               if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            end
         end

         // The first word after entering ALIGN or changing slip only seeds the comparison.
         if (enter_align) begin
            seed      <= 1'b1;
            match_cnt <= '0;
            slip_cnt  <= '0;
         end
         if (enter_locked) miss_cnt <= '0;
      end
   end
endmodule

// File: tb/tb_loopback_link_ctrl.sv
// Randomized self-checking bench for loopback_link_ctrl against a behavioural link model.
// Inputs change on the falling edge; outputs are checked just after, before the next rising edge.
module tb_loopback_link_ctrl;
   localparam int LOCK_MATCHES = 16;
   localparam int LOSS_ERRS    = 4;
   localparam int PHY_TIMEOUT  = 4096;
   localparam int MAX_SLIPS    = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        tx_rst_seq_done, rx_rst_seq_done, tx_pll_locked, rx_pll_locked;
   logic        phy_dly_rdy, phy_vtc_rdy, rx_fifo_empty, rx_data_valid;
   logic [7:0]  rx_data;
   logic        rx_fifo_rd_en, source_rst, aligned_valid, link_locked, link_error;
   logic [7:0]  aligned_data;
   logic [2:0]  slip, state;
   logic [15:0] err_count;

   int checks = 0;
   int errors = 0;

   int         m_state, m_tmo, m_match, m_slips, m_miss, m_slip, m_err;
   bit         m_seed, m_av;
   logic [7:0] m_prev, m_last, m_ad;

   logic [7:0] c_cur, c_prev;
   int         shift_amt;
   bit         random_data;

   always #5 clk = ~clk;

   loopback_link_ctrl #(
      .LOCK_MATCHES(LOCK_MATCHES), .LOSS_ERRS(LOSS_ERRS),
      .PHY_TIMEOUT(PHY_TIMEOUT), .MAX_SLIPS(MAX_SLIPS)
   ) dut (
      .clk(clk), .rst(rst),
      .tx_rst_seq_done(tx_rst_seq_done), .rx_rst_seq_done(rx_rst_seq_done),
      .tx_pll_locked(tx_pll_locked), .rx_pll_locked(rx_pll_locked),
      .phy_dly_rdy(phy_dly_rdy), .phy_vtc_rdy(phy_vtc_rdy),
      .rx_fifo_empty(rx_fifo_empty), .rx_fifo_rd_en(rx_fifo_rd_en),
      .rx_data_valid(rx_data_valid), .rx_data(rx_data),
      .source_rst(source_rst), .aligned_data(aligned_data), .aligned_valid(aligned_valid),
      .slip(slip), .state(state), .link_locked(link_locked), .link_error(link_error),
      .err_count(err_count)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic modelReset();
      m_state = 0; m_tmo = 0; m_match = 0; m_slips = 0; m_miss = 0; m_slip = 0; m_err = 0;
      m_seed = 0; m_av = 0; m_prev = 0; m_last = 0; m_ad = 0;
   endtask

   task automatic enterAlign();
      m_state = 3; m_seed = 1; m_match = 0; m_slips = 0;
   endtask

   // One clock of the link as the rules describe it, using the inputs present before the edge.
   task automatic modelStep();
      bit ok, good;
      logic [15:0] pair;
      logic [7:0]  cand;
      ok   = tx_rst_seq_done & rx_rst_seq_done & tx_pll_locked & rx_pll_locked & phy_dly_rdy & phy_vtc_rdy;
      pair = {rx_data, m_prev} >> m_slip;
      cand = pair[7:0];
      good = (cand == 8'(m_last + 8'd1));
      if (rst) begin
         modelReset();
         return;
      end
      m_av = 0;
      case (m_state)
         0: begin m_state = 1; m_tmo = 0; end
         1: begin
            if (ok) m_state = 2;
            else if (m_tmo == PHY_TIMEOUT - 1) m_state = 6;
            else m_tmo++;
         end
         2, 3, 4: begin
            if (!ok) begin
               m_state = 1; m_tmo = 0;
            end else if (m_state == 2) begin
               if (!rx_fifo_empty) enterAlign();
            end else if (m_state == 3 && rx_data_valid) begin
               m_last = cand;
               if (m_seed) m_seed = 0;
               else if (good) begin
                  m_match++;
                  if (m_match == LOCK_MATCHES) begin m_state = 4; m_miss = 0; end
               end else begin
                  m_match = 0; m_slip = (m_slip + 1) % 8; m_slips++; m_seed = 1;
                  if (m_slips == MAX_SLIPS) m_state = 6;
               end
            end else if (m_state == 4 && rx_data_valid) begin
               m_av = 1; m_ad = cand; m_last = cand;
               if (good) m_miss = 0;
               else begin
                  m_miss++;
                  if (m_err < 65535) m_err++;
               end
               if (m_miss == LOSS_ERRS) enterAlign();
            end
         end
         default: ;
      endcase
      if (rx_data_valid) m_prev = rx_data;
   endtask

   task automatic checkAll();
      bit active;
      active = (m_state == 2 || m_state == 3 || m_state == 4);
      checkOutput("state", 32'(state), 32'(m_state));
      checkOutput("source_rst", 32'(source_rst), 32'(!active));
      checkOutput("rx_fifo_rd_en", 32'(rx_fifo_rd_en), 32'(active && !rx_fifo_empty));
      checkOutput("link_locked", 32'(link_locked), 32'(m_state == 4));
      checkOutput("link_error", 32'(link_error), 32'(m_state == 6));
      checkOutput("slip", 32'(slip), 32'(m_slip));
      checkOutput("err_count", 32'(err_count), 32'(m_err));
      checkOutput("aligned_valid", 32'(aligned_valid), 32'(m_av));
      checkOutput("aligned_data", 32'(aligned_data), 32'(m_ad));
   endtask

   // Called at a falling edge with inputs already driven; returns at the next falling edge.
   task automatic applyStimulus();
      #1;
      checkAll();
      modelStep();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Serialised counter stream seen through a bit offset of shift_amt.
   task automatic emitWord(input bit corrupt);
      logic [15:0] w;
      w = {c_cur, c_prev} << shift_amt;
      rx_data = random_data ? 8'($urandom) : w[15:8];
      if (corrupt) rx_data = rx_data ^ 8'hFF;
      rx_data_valid = 1'b1;
      c_prev = c_cur;
      c_cur  = c_cur + 8'd1;
   endtask

   task automatic randomCycle();
      rx_fifo_empty = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 3) != 0) emitWord(1'b0);
      else begin
         rx_data_valid = 1'b0;
         rx_data = 8'($urandom);
      end
      applyStimulus();
   endtask

   task automatic cleanCycle(input bit corrupt);
      rx_fifo_empty = ($urandom_range(0, 4) == 0);
      emitWord(corrupt);
      applyStimulus();
   endtask

   task automatic setPhy(input logic v);
      tx_rst_seq_done = v; rx_rst_seq_done = v; tx_pll_locked = v;
      rx_pll_locked = v; phy_dly_rdy = v; phy_vtc_rdy = v;
   endtask

   task automatic doReset();
      rst = 1'b1;
      rx_data_valid = 1'b0;
      applyStimulus();
      rst = 1'b0;
      c_cur = 8'($urandom);
      c_prev = c_cur - 8'd1;
   endtask

   task automatic runUntilState(input int target, input int limit, input string tag);
      int n = 0;
      while (32'(state) != target && n < limit) begin
         randomCycle();
         n++;
      end
      checkOutput(tag, 32'(state), 32'(target));
   endtask

   initial begin
      int n_wait;
      rst = 1'b1; setPhy(1'b0);
      rx_fifo_empty = 1'b1; rx_data_valid = 1'b0; rx_data = 8'h00;
      shift_amt = 0; random_data = 0;
      c_cur = 8'($urandom); c_prev = c_cur - 8'd1;
      @(posedge clk);
      @(negedge clk);
      modelReset();
      applyStimulus();
      doReset();

      $display("[TB] zero-slip bring-up");
      repeat (10) randomCycle();
      setPhy(1'b1);
      runUntilState(4, 400, "lock_zero_slip");
      checkOutput("slip_zero", 32'(slip), 32'd0);

      $display("[TB] three-bit offset with counter wrap");
      doReset();
      shift_amt = 3;
      runUntilState(4, 600, "lock_slip3");
      checkOutput("slip_three", 32'(slip), 32'd3);
      for (int i = 0; i < 300; i++) begin
         cleanCycle(1'b0);
         checkOutput("aligned_cnt", 32'(aligned_data), 32'(8'(c_prev - 8'd1)));
      end
      checkOutput("wrap_no_err", 32'(err_count), 32'd0);

      $display("[TB] isolated and burst corruption");
      for (int i = 0; i < 3; i++) begin
         cleanCycle(1'b1);
         repeat (6) cleanCycle(1'b0);
      end
      checkOutput("isolated_stays_locked", 32'(link_locked), 32'd1);
      repeat (6) cleanCycle(1'b1);
      repeat (2) cleanCycle(1'b0);
      runUntilState(4, 400, "relock_after_burst");
      checkOutput("relock_slip", 32'(slip), 32'd3);

      $display("[TB] PHY drop while locked");
      tx_rst_seq_done = 1'b0;
      randomCycle();
      checkOutput("drop_state", 32'(state), 32'd1);
      checkOutput("drop_source_rst", 32'(source_rst), 32'd1);
      checkOutput("drop_rd_en", 32'(rx_fifo_rd_en), 32'd0);
      tx_rst_seq_done = 1'b1;
      runUntilState(4, 400, "relock_after_drop");

      $display("[TB] PHY timeout");
      doReset();
      rx_pll_locked = 1'b0;
      n_wait = 0;
      for (int i = 0; i < PHY_TIMEOUT + 100; i++) begin
         randomCycle();
         if (state == 3'd1) n_wait++;
         if (state == 3'd6) break;
      end
      checkOutput("timeout_len", 32'(n_wait), 32'(PHY_TIMEOUT));
      rx_pll_locked = 1'b1;
      repeat (20) randomCycle();
      checkOutput("fail_sticky", 32'(state), 32'd6);
      checkOutput("fail_source_rst", 32'(source_rst), 32'd1);

      $display("[TB] random data and reset mid-align");
      doReset();
      random_data = 1;
      runUntilState(6, 2000, "slip_exhaust_fail");
      doReset();
      runUntilState(3, 400, "reach_align");
      repeat (3) randomCycle();
      rst = 1'b1;
      applyStimulus();
      rst = 1'b0;
      #1;
      checkOutput("rst_state", 32'(state), 32'd0);
      checkOutput("rst_source_rst", 32'(source_rst), 32'd1);
      checkOutput("rst_slip", 32'(slip), 32'd0);
      checkOutput("rst_aligned_valid", 32'(aligned_valid), 32'd0);
      randomCycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
